// File: rtl/vram_scan_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rx78_video_pkg
//  Description : Shared constants and fetch FSM encoding for the VRAM scan
//                reader (display geometry, VRAM address width, plane count).
//  Revision    : 1.0  initial release
// ============================================================================
package rx78_video_pkg;

    localparam int H_BYTES     = 24;   // bytes per plane per line (192 px / 8)
    localparam int V_LINES     = 184;  // active display lines
    localparam int VRAM_ADDR_W = 13;   // 8 KB plane address width
    localparam int PLANES      = 6;    // fg1, fg2, fg3, bg1, bg2, bg3

    // Fetch sequencer: present address, wait one clk of RAM latency, capture.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_CAPT = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/vram_scan_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : vram_scan_reader_if
//  Description : Video-side port bundle of the six VRAM plane dual-port RAMs.
//                The reader (master) drives the address, the RAMs (slave)
//                return one byte per plane one clk later.
//  Revision    : 1.0  initial release
// ============================================================================
interface vram_scan_reader_if #(
    parameter int ADDR_W = rx78_video_pkg::VRAM_ADDR_W
) ();

    logic [ADDR_W-1:0] vaddr;
    logic [7:0]        fg1;
    logic [7:0]        fg2;
    logic [7:0]        fg3;
    logic [7:0]        bg1;
    logic [7:0]        bg2;
    logic [7:0]        bg3;

    modport master (
        output vaddr,
        input  fg1, fg2, fg3, bg1, bg2, bg3
    );

    modport slave (
        input  vaddr,
        output fg1, fg2, fg3, bg1, bg2, bg3
    );

endinterface
`default_nettype wire

// File: rtl/vram_scan_reader_plane_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : plane_shifter
//  Description : One plane's 8-bit load/shift register with a remaining-bit
//                count. Bit 0 is the leftmost pixel; the register shifts
//                right. The emitted pixel bit is registered on the strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module plane_shifter (
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic       clear,   // new line: drop any pending bits
    input  wire logic       load,    // take a fresh byte and emit its bit 0
    input  wire logic       shift,   // emit the next pending bit
    input  wire logic       blank,   // emit 0 without consuming a bit
    input  wire logic [7:0] din,
    output logic            pix,
    output logic            empty
);

    logic [7:0] r_sreg;
    logic [3:0] r_count;

    // Holds the not-yet-displayed bits; the pixel output only changes on a strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sreg  <= '0;
            r_count <= '0;
            pix     <= 1'b0;
        end else if (clear) begin
            r_sreg  <= '0;
            r_count <= '0;
        end else if (load) begin
            pix     <= din[0];
            r_sreg  <= {1'b0, din[7:1]};
            r_count <= 4'd7;
        end else if (shift && (r_count != 4'd0)) begin
            pix     <= r_sreg[0];
            r_sreg  <= {1'b0, r_sreg[7:1]};
            r_count <= r_count - 4'd1;
        end else if (blank) begin
            pix     <= 1'b0;
        end
    end

    assign empty = (r_count == 4'd0);

endmodule
`default_nettype wire

// File: rtl/vram_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module      : vram_scan_reader
//  Description : Raster-order reader of the six VRAM planes. Keeps one byte
//                per plane prefetched ahead of display and serializes it into
//                3-bit foreground/background codes per pixel.
//  Revision    : 1.0  initial release
// ============================================================================
module vram_scan_reader #(
    parameter int H_BYTES = rx78_video_pkg::H_BYTES,
    parameter int V_LINES = rx78_video_pkg::V_LINES,
    parameter int ADDR_W  = rx78_video_pkg::VRAM_ADDR_W
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input  wire logic          ce_pix,
    input  wire logic          frame_start,
    input  wire logic          line_start,
    input  wire logic          active,
    vram_scan_reader_if.master vram,
    output logic [2:0]         fg,
    output logic [2:0]         bg,
    output logic               pix_valid,
    output logic               underrun
);

    import rx78_video_pkg::*;

    localparam int c_idx_w  = $clog2(H_BYTES + 1);
    localparam int c_line_w = $clog2(V_LINES + 1);
    localparam logic [c_idx_w-1:0]  c_h_bytes_idx  = c_idx_w'(H_BYTES);
    localparam logic [ADDR_W-1:0]   c_h_bytes_addr = ADDR_W'(H_BYTES);
    localparam logic [c_line_w-1:0] c_v_lines      = c_line_w'(V_LINES);

    // ------------------------------------------------------------------
    // Line bookkeeping
    // ------------------------------------------------------------------
    logic [c_line_w-1:0] r_line_cnt;
    logic [ADDR_W-1:0]   r_line_base;
    logic                r_line_seen;   // a line has started since frame_start
    logic [c_line_w-1:0] w_next_cnt;
    logic [ADDR_W-1:0]   w_next_base;
    logic                w_next_shown;

    // Counter/base the next line_start would establish; same-cycle frame_start wins.
    always_comb begin
        w_next_cnt  = r_line_cnt;
        w_next_base = r_line_base;
        if (frame_start || !r_line_seen) begin
            w_next_cnt  = '0;
            w_next_base = '0;
        end else if (r_line_cnt < c_v_lines) begin
            w_next_cnt  = r_line_cnt + 1'b1;
            w_next_base = r_line_base + c_h_bytes_addr;
        end
        w_next_shown = (w_next_cnt < c_v_lines);
    end

    // Line counter (saturating at V_LINES) and running line base address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_line_cnt  <= '0;
            r_line_base <= '0;
            r_line_seen <= 1'b0;
        end else if (line_start) begin
            r_line_cnt  <= w_next_cnt;
            r_line_base <= w_next_base;
            r_line_seen <= 1'b1;
        end else if (frame_start) begin
            r_line_cnt  <= '0;
            r_line_base <= '0;
            r_line_seen <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic               w_fetch_go;
    logic               w_capture;
    logic [c_idx_w-1:0] r_byte_idx;
    logic               r_pf_full;
    logic [ADDR_W-1:0]  r_vaddr;
    logic [7:0]         r_pf [PLANES];
    logic [7:0]         w_plane_data [PLANES];
    logic               w_load;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: fetch whenever the prefetch slot is free and bytes remain.
    always_comb begin
        w_state_nxt = r_state;
        w_fetch_go  = 1'b0;
        w_capture   = 1'b0;
        if (line_start) begin
            w_state_nxt = w_next_shown ? ST_ADDR : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_pf_full && (r_byte_idx < c_h_bytes_idx)) begin
                        w_state_nxt = ST_ADDR;
                        w_fetch_go  = 1'b1;
                    end
                end
                ST_ADDR: w_state_nxt = ST_CAPT;
                ST_CAPT: begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_plane_data[0] = vram.fg1;
    assign w_plane_data[1] = vram.fg2;
    assign w_plane_data[2] = vram.fg3;
    assign w_plane_data[3] = vram.bg1;
    assign w_plane_data[4] = vram.bg2;
    assign w_plane_data[5] = vram.bg3;

    // Address, byte index and prefetch buffer. Out of reset byte_idx sits at
    // the end-of-line value so nothing is fetched until the first line_start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vaddr    <= '0;
            r_byte_idx <= c_h_bytes_idx;
            r_pf_full  <= 1'b0;
            for (int i = 0; i < PLANES; i++) begin
                r_pf[i] <= '0;
            end
        end else if (line_start) begin
            r_byte_idx <= w_next_shown ? '0 : c_h_bytes_idx;
            r_pf_full  <= 1'b0;
            if (w_next_shown) begin
                r_vaddr <= w_next_base;
            end
        end else begin
            if (w_fetch_go) begin
                r_vaddr <= r_line_base + ADDR_W'(r_byte_idx);
            end
            if (w_capture) begin
                for (int i = 0; i < PLANES; i++) begin
                    r_pf[i] <= w_plane_data[i];
                end
                r_pf_full  <= 1'b1;
                r_byte_idx <= r_byte_idx + 1'b1;
            end else if (w_load) begin
                r_pf_full <= 1'b0;
            end
        end
    end

    assign vram.vaddr = r_vaddr;

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    logic              w_shift;
    logic              w_blank;
    logic              w_starve;
    logic [PLANES-1:0] w_empty_vec;
    logic [PLANES-1:0] w_pix;
    logic              w_empty;

    assign w_empty = &w_empty_vec;

    // Per-pixel decision; a coincident line_start takes precedence.
    always_comb begin
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_blank  = 1'b0;
        w_starve = 1'b0;
        if (ce_pix && !line_start) begin
            if (!active) begin
                w_blank = 1'b1;
            end else if (w_empty && r_pf_full) begin
                w_load = 1'b1;
            end else if (!w_empty) begin
                w_shift = 1'b1;
            end else begin
                w_blank  = 1'b1;
                w_starve = (r_byte_idx < c_h_bytes_idx);
            end
        end
    end

    generate
        for (genvar g = 0; g < PLANES; g++) begin : g_plane
            plane_shifter u_shifter (
                .clk     (clk),
                .reset_n (reset_n),
                .clear   (line_start),
                .load    (w_load),
                .shift   (w_shift),
                .blank   (w_blank),
                .din     (r_pf[g]),
                .pix     (w_pix[g]),
                .empty   (w_empty_vec[g])
            );
        end
    endgenerate

    assign fg = w_pix[2:0];
    assign bg = w_pix[5:3];

    // Pixel-valid flag and the sticky starvation flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (ce_pix && !line_start) begin
                pix_valid <= w_load | w_shift;
            end
            if (w_starve) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_scan_reader
//  Description : Self-checking bench for vram_scan_reader. Random VRAM
//                contents; expected pixels come from the raster rule
//                pixel k of line L = bit k%8 of byte (L*24 + k/8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vram_scan_reader;

    localparam int H   = 24;
    localparam int V   = 184;
    localparam int PIX = H * 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce_pix = 1'b0;
    logic       frame_start = 1'b0;
    logic       line_start = 1'b0;
    logic       active = 1'b0;
    logic [2:0] fg;
    logic [2:0] bg;
    logic       pix_valid;
    logic       underrun;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [6][8192];

    vram_scan_reader_if #(.ADDR_W(13)) vif ();

    vram_scan_reader #(.H_BYTES(H), .V_LINES(V), .ADDR_W(13)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce_pix      (ce_pix),
        .frame_start (frame_start),
        .line_start  (line_start),
        .active      (active),
        .vram        (vif),
        .fg          (fg),
        .bg          (bg),
        .pix_valid   (pix_valid),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // Dual-port RAM video side: registered read, one clk of latency.
    always @(posedge clk) begin
        vif.fg1 <= mem[0][vif.vaddr];
        vif.fg2 <= mem[1][vif.vaddr];
        vif.fg3 <= mem[2][vif.vaddr];
        vif.bg1 <= mem[3][vif.vaddr];
        vif.bg2 <= mem[4][vif.vaddr];
        vif.bg3 <= mem[5][vif.vaddr];
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (tests=%0d failed=%0d)", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {fg, bg, pix_valid} for pixel k of a displayed line.
    function automatic logic [6:0] exp_pix(input int line, input int k);
        int         a;
        logic [2:0] f;
        logic [2:0] b;
        a = line * H + k / 8;
        for (int p = 0; p < 3; p++) begin
            f[p] = mem[p][a][k % 8];
            b[p] = mem[p + 3][a][k % 8];
        end
        return {f, b, 1'b1};
    endfunction

    task automatic pulse_ce(input logic act);
        ce_pix = 1'b1;
        active = act;
        @(negedge clk);
        ce_pix = 1'b0;
        active = 1'b0;
    endtask

    // One line: line_start, then 192 active pixels. gap_at inserts 5 inactive
    // pixels before that index; abort_at returns one clk after the pixel
    // before it (so the next line_start lands while a fetch is in ADDR).
    task automatic run_line(input int line, input int spacing, input int gap_at,
                            input int abort_at, input logic [12:0] hold_addr);
        int         lead;
        bit         shown;
        logic [6:0] e;
        lead  = int'($urandom_range(5, 3));
        shown = (line < V);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        check("first_vaddr", 32'(vif.vaddr), shown ? 32'(line * H) : 32'(hold_addr));
        repeat (lead - 1) @(negedge clk);
        for (int k = 0; k < PIX; k++) begin
            if (k == abort_at) begin
                @(negedge clk);
                return;
            end
            if (k > 0) repeat (spacing - 1) @(negedge clk);
            if (k == gap_at) begin
                for (int g = 0; g < 5; g++) begin
                    pulse_ce(1'b0);
                    check("gap_pixel", 32'({fg, bg, pix_valid}), 32'd0);
                    repeat (spacing - 1) @(negedge clk);
                end
            end
            pulse_ce(1'b1);
            e = shown ? exp_pix(line, k) : 7'd0;
            check($sformatf("pixel_l%0d_k%0d", line, k), 32'({fg, bg, pix_valid}), 32'(e));
        end
        check("last_vaddr", 32'(vif.vaddr), shown ? 32'(line * H + H - 1) : 32'(hold_addr));
        check("underrun_clear", 32'(underrun), 32'd0);
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    initial begin
        for (int p = 0; p < 6; p++) begin
            for (int a = 0; a < 8192; a++) begin
                mem[p][a] = 8'($urandom);
            end
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_vaddr", 32'(vif.vaddr), 32'd0);
        check("rst_pix", 32'({fg, bg, pix_valid}), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Line 0 at a relaxed pixel rate, then past-end-of-line pixels
        pulse_frame();
        run_line(0, 4, -1, -1, 13'd0);
        for (int i = 0; i < 2; i++) begin
            repeat (3) @(negedge clk);
            pulse_ce(1'b1);
            check("eol_pixel", 32'({fg, bg, pix_valid}), 32'd0);
        end
        check("eol_underrun", 32'(underrun), 32'd0);

        // Line 1 at the fastest pixel rate
        run_line(1, 2, -1, -1, 13'd0);
        // Line 2 with an inactive gap in the middle of byte 1
        run_line(2, 4, 13, -1, 13'd0);
        // Line 3 cut short while fetching byte 2; line 4 must be clean
        run_line(3, 4, -1, 9, 13'd0);
        run_line(4, 3, -1, -1, 13'd0);

        // Advance through lines 5..182 without displaying them
        for (int l = 5; l < V - 1; l++) begin
            line_start = 1'b1;
            @(negedge clk);
            line_start = 1'b0;
            repeat (4) @(negedge clk);
        end
        run_line(V - 1, 3, -1, -1, 13'd0);
        run_line(V, 3, -1, -1, 13'((V - 1) * H + H - 1));

        // frame_start with line_start in the same cycle, first pixel too early
        frame_start = 1'b1;
        line_start  = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        line_start  = 1'b0;
        check("same_cycle_vaddr", 32'(vif.vaddr), 32'd0);
        pulse_ce(1'b1);
        check("early_pixel", 32'({fg, bg, pix_valid}), 32'd0);
        check("early_underrun", 32'(underrun), 32'd1);

        // Asynchronous reset in the middle of a displayed line
        repeat (4) @(negedge clk);
        pulse_frame();
        run_line(0, 2, -1, 20, 13'd0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_vaddr", 32'(vif.vaddr), 32'd0);
        check("arst_pix", 32'({fg, bg, pix_valid}), 32'd0);
        check("arst_underrun", 32'(underrun), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        pulse_frame();
        run_line(0, 4, -1, -1, 13'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
